pe_array_seq_ctrl: RTL

//  Next-generation PE array sequencer. Drives MAC enables, RF read addresses and psum addresses for a ROW x COL PE array.

---
 rtl/pe_array_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pe_array_seq_ctrl
//   Sequencer for a ROW x COL PE array. It waits for the double-buffered
//   activation and weight RFs to be filled, then sweeps the RF read address (k)
//   and the psum address (p) over a K x P tile. It runs N tiles back to back
//   with no bubble when the other buffer pair is already full. After that it
//   drains the MAC pipeline and hands the psums to psum_su_adder.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   start, abort          : run start pulse (IDLE only) / synchronous clear
//   cfg_k_len/p_len/n_tiles/row_mask : run configuration, latched on start
//   *_buf{1,2}_send_finish: gbf controller has filled a buffer
//   su_add_finish         : psum_su_adder has consumed the psums
//   MAC_en                : per-PE MAC enable, bit r*COL+c -> PE (r,c)
//   actv_sel, wgt_sel     : RF buffer being read (0 = buf1, 1 = buf2)
//   actv_r_addr, wgt_r_addr, psum_en, psum_addr : compute-side addressing
//   psum_wr_en, psum_write_addr : psum_en/psum_addr delayed MAC_LAT cycles
//   *_rf{1,2}_need_data   : buffer fill requests
//   pe_psum_finish        : psums ready (level); conv_finish, turn_off: pulses
//   busy                  : state != IDLE
// -----------------------------------------------------------------------------
module pe_array_seq_ctrl #(
    parameter int ROW                = 16,
    parameter int COL                = 16,
    parameter int RF_ADDR_BITWIDTH   = 2,
    parameter int PSUM_ADDR_BITWIDTH = 2,
    parameter int TILE_BITWIDTH      = 8,
    parameter int MAC_LAT            = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic [RF_ADDR_BITWIDTH:0]       cfg_k_len,
    input  logic [PSUM_ADDR_BITWIDTH:0]     cfg_p_len,
    input  logic [TILE_BITWIDTH-1:0]        cfg_n_tiles,
    input  logic [ROW-1:0]                  cfg_row_mask,
    input  logic                            actv_buf1_send_finish,
    input  logic                            actv_buf2_send_finish,
    input  logic                            wgt_buf1_send_finish,
    input  logic                            wgt_buf2_send_finish,
    input  logic                            su_add_finish,
    output logic [ROW*COL-1:0]              MAC_en,
    output logic                            actv_sel,
    output logic                            wgt_sel,
    output logic [RF_ADDR_BITWIDTH-1:0]     actv_r_addr,
    output logic [RF_ADDR_BITWIDTH-1:0]     wgt_r_addr,
    output logic                            psum_en,
    output logic [PSUM_ADDR_BITWIDTH-1:0]   psum_addr,
    output logic                            psum_wr_en,
    output logic [PSUM_ADDR_BITWIDTH-1:0]   psum_write_addr,
    output logic                            actv_rf1_need_data,
    output logic                            actv_rf2_need_data,
    output logic                            wgt_rf1_need_data,
    output logic                            wgt_rf2_need_data,
    output logic                            pe_psum_finish,
    output logic                            conv_finish,
    output logic                            turn_off,
    output logic                            busy
);

    localparam int KW = RF_ADDR_BITWIDTH + 1;
    localparam int PW = PSUM_ADDR_BITWIDTH + 1;
    localparam logic [KW-1:0] K_DEPTH = KW'(1 << RF_ADDR_BITWIDTH);
    localparam logic [PW-1:0] P_DEPTH = PW'(1 << PSUM_ADDR_BITWIDTH);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [TILE_BITWIDTH-1:0] T_ONE = TILE_BITWIDTH'(1);
    localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_COMPUTE   = 3'd2,
        S_DRAIN     = 3'd3,
        S_WAIT_SU   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // A length of 0 or above the RF depth selects the full depth.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] v);
        if ((v == {KW{1'b0}}) || (v > K_DEPTH)) begin
            return K_DEPTH;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [PW-1:0] clamp_p(input logic [PW-1:0] v);
        if ((v == {PW{1'b0}}) || (v > P_DEPTH)) begin
            return P_DEPTH;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [TILE_BITWIDTH-1:0] clamp_n(input logic [TILE_BITWIDTH-1:0] v);
        if (v == {TILE_BITWIDTH{1'b0}}) begin
            return T_ONE;
        end else begin
            return v;
        end
    endfunction

    // Each row-mask bit is replicated across all COL PEs of that row.
    function automatic logic [ROW*COL-1:0] mask_expand(input logic [ROW-1:0] m);
        logic [ROW*COL-1:0] e;
        e = {(ROW*COL){1'b0}};
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                e[r*COL+c] = m[r];
            end
        end
        return e;
    endfunction

    state_t                        state_r;
    logic [KW-1:0]                 k_len_r;
    logic [PW-1:0]                 p_len_r;
    logic [TILE_BITWIDTH-1:0]      n_tiles_r;
    logic [ROW-1:0]                mask_r;
    logic [RF_ADDR_BITWIDTH-1:0]   k_r;
    logic [PSUM_ADDR_BITWIDTH-1:0] p_r;
    logic                          sel_r;
    logic [TILE_BITWIDTH-1:0]      tile_cnt_r;
    logic [2:0]                    drain_cnt_r;
    logic [1:0]                    actv_full_r;
    logic [1:0]                    wgt_full_r;
    logic [TILE_BITWIDTH-1:0]      actv_sent_r;
    logic [TILE_BITWIDTH-1:0]      wgt_sent_r;
    logic [1:0]                    actv_need_r;
    logic [1:0]                    wgt_need_r;
    logic [ROW*COL-1:0]            mac_en_r;
    logic                          psum_en_r;
    logic                          pe_psum_finish_r;
    logic                          conv_finish_r;
    logic                          turn_off_r;
    logic                          busy_r;
    logic                          wr_pipe_r [MAC_LAT];
    logic [PSUM_ADDR_BITWIDTH-1:0] waddr_pipe_r [MAC_LAT];

    logic [1:0]               actv_acc_s;
    logic [1:0]               wgt_acc_s;
    logic [1:0]               actv_full_set_s;
    logic [1:0]               wgt_full_set_s;
    logic [1:0]               clr_mask_s;
    logic [1:0]               actv_full_next_s;
    logic [1:0]               wgt_full_next_s;
    logic [TILE_BITWIDTH-1:0] actv_sent_next_s;
    logic [TILE_BITWIDTH-1:0] wgt_sent_next_s;
    logic                     k_last_s;
    logic                     p_last_s;
    logic                     tile_end_s;
    logic                     tile_last_s;
    logic                     cur_ready_s;
    logic                     nxt_ready_s;

    // A fill is accepted only while running and only into an empty buffer.
    assign actv_acc_s = {2{busy_r}} & ~actv_full_r & {actv_buf2_send_finish, actv_buf1_send_finish};
    assign wgt_acc_s  = {2{busy_r}} & ~wgt_full_r  & {wgt_buf2_send_finish,  wgt_buf1_send_finish};
    assign actv_full_set_s = actv_full_r | actv_acc_s;
    assign wgt_full_set_s  = wgt_full_r  | wgt_acc_s;

    assign k_last_s    = ({1'b0, k_r} == (k_len_r - K_ONE));
    assign p_last_s    = ({1'b0, p_r} == (p_len_r - P_ONE));
    assign tile_end_s  = (state_r == S_COMPUTE) & k_last_s & p_last_s;
    assign tile_last_s = ((tile_cnt_r + T_ONE) == n_tiles_r);

    // The buffer being read is released on the last cycle of its tile.
    assign clr_mask_s       = tile_end_s ? (sel_r ? 2'b10 : 2'b01) : 2'b00;
    assign actv_full_next_s = actv_full_set_s & ~clr_mask_s;
    assign wgt_full_next_s  = wgt_full_set_s  & ~clr_mask_s;

    assign actv_sent_next_s = actv_sent_r + TILE_BITWIDTH'(actv_acc_s[0]) + TILE_BITWIDTH'(actv_acc_s[1]);
    assign wgt_sent_next_s  = wgt_sent_r  + TILE_BITWIDTH'(wgt_acc_s[0])  + TILE_BITWIDTH'(wgt_acc_s[1]);

    assign cur_ready_s = actv_full_r[sel_r] & wgt_full_r[sel_r];
    // Same-cycle fills count, so a fill landing on the last cycle avoids a bubble.
    assign nxt_ready_s = actv_full_set_s[~sel_r] & wgt_full_set_s[~sel_r];

    // Sequencer state machine with all control outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= S_IDLE;
            k_len_r          <= {KW{1'b0}};
            p_len_r          <= {PW{1'b0}};
            n_tiles_r        <= {TILE_BITWIDTH{1'b0}};
            mask_r           <= {ROW{1'b0}};
            k_r              <= {RF_ADDR_BITWIDTH{1'b0}};
            p_r              <= {PSUM_ADDR_BITWIDTH{1'b0}};
            sel_r            <= 1'b0;
            tile_cnt_r       <= {TILE_BITWIDTH{1'b0}};
            drain_cnt_r      <= 3'd0;
            actv_full_r      <= 2'b00;
            wgt_full_r       <= 2'b00;
            actv_sent_r      <= {TILE_BITWIDTH{1'b0}};
            wgt_sent_r       <= {TILE_BITWIDTH{1'b0}};
            actv_need_r      <= 2'b00;
            wgt_need_r       <= 2'b00;
            mac_en_r         <= {(ROW*COL){1'b0}};
            psum_en_r        <= 1'b0;
            pe_psum_finish_r <= 1'b0;
            conv_finish_r    <= 1'b0;
            turn_off_r       <= 1'b0;
            busy_r           <= 1'b0;
        end else if (abort) begin
            state_r          <= S_IDLE;
            k_len_r          <= {KW{1'b0}};
            p_len_r          <= {PW{1'b0}};
            n_tiles_r        <= {TILE_BITWIDTH{1'b0}};
            mask_r           <= {ROW{1'b0}};
            k_r              <= {RF_ADDR_BITWIDTH{1'b0}};
            p_r              <= {PSUM_ADDR_BITWIDTH{1'b0}};
            sel_r            <= 1'b0;
            tile_cnt_r       <= {TILE_BITWIDTH{1'b0}};
            drain_cnt_r      <= 3'd0;
            actv_full_r      <= 2'b00;
            wgt_full_r       <= 2'b00;
            actv_sent_r      <= {TILE_BITWIDTH{1'b0}};
            wgt_sent_r       <= {TILE_BITWIDTH{1'b0}};
            actv_need_r      <= 2'b00;
            wgt_need_r       <= 2'b00;
            mac_en_r         <= {(ROW*COL){1'b0}};
            psum_en_r        <= 1'b0;
            pe_psum_finish_r <= 1'b0;
            conv_finish_r    <= 1'b0;
            turn_off_r       <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            actv_full_r <= actv_full_next_s;
            wgt_full_r  <= wgt_full_next_s;
            actv_sent_r <= actv_sent_next_s;
            wgt_sent_r  <= wgt_sent_next_s;
            // Requests are computed from current flags, so they lag by one cycle.
            actv_need_r <= {2{busy_r}} & ~actv_full_r & {2{actv_sent_r < n_tiles_r}};
            wgt_need_r  <= {2{busy_r}} & ~wgt_full_r  & {2{wgt_sent_r  < n_tiles_r}};

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        k_len_r     <= clamp_k(cfg_k_len);
                        p_len_r     <= clamp_p(cfg_p_len);
                        n_tiles_r   <= clamp_n(cfg_n_tiles);
                        mask_r      <= cfg_row_mask;
                        sel_r       <= 1'b0;
                        tile_cnt_r  <= {TILE_BITWIDTH{1'b0}};
                        actv_full_r <= 2'b00;
                        wgt_full_r  <= 2'b00;
                        actv_sent_r <= {TILE_BITWIDTH{1'b0}};
                        wgt_sent_r  <= {TILE_BITWIDTH{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= S_WAIT_DATA;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                S_WAIT_DATA: begin
                    if (cur_ready_s) begin
                        k_r       <= {RF_ADDR_BITWIDTH{1'b0}};
                        p_r       <= {PSUM_ADDR_BITWIDTH{1'b0}};
                        mac_en_r  <= mask_expand(mask_r);
                        psum_en_r <= 1'b1;
                        state_r   <= S_COMPUTE;
                    end else begin
                        state_r   <= S_WAIT_DATA;
                    end
                end
                S_COMPUTE: begin
                    if (tile_end_s) begin
                        sel_r      <= ~sel_r;
                        tile_cnt_r <= tile_cnt_r + T_ONE;
                        if (tile_last_s) begin
                            mac_en_r    <= {(ROW*COL){1'b0}};
                            psum_en_r   <= 1'b0;
                            drain_cnt_r <= 3'd0;
                            state_r     <= S_DRAIN;
                        end else if (nxt_ready_s) begin
                            k_r <= {RF_ADDR_BITWIDTH{1'b0}};
                            p_r <= {PSUM_ADDR_BITWIDTH{1'b0}};
                        end else begin
                            mac_en_r  <= {(ROW*COL){1'b0}};
                            psum_en_r <= 1'b0;
                            state_r   <= S_WAIT_DATA;
                        end
                    end else if (k_last_s) begin
                        k_r <= {RF_ADDR_BITWIDTH{1'b0}};
                        p_r <= p_r + {{(PSUM_ADDR_BITWIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        k_r <= k_r + {{(RF_ADDR_BITWIDTH-1){1'b0}}, 1'b1};
                    end
                end
                S_DRAIN: begin
                    // Hold here until the last psum write has left the delay pipe.
                    if (drain_cnt_r == DRAIN_LAST) begin
                        pe_psum_finish_r <= 1'b1;
                        state_r          <= S_WAIT_SU;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 3'd1;
                    end
                end
                S_WAIT_SU: begin
                    if (su_add_finish) begin
                        pe_psum_finish_r <= 1'b0;
                        conv_finish_r    <= 1'b1;
                        turn_off_r       <= 1'b1;
                        state_r          <= S_DONE;
                    end else begin
                        pe_psum_finish_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    conv_finish_r <= 1'b0;
                    turn_off_r    <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= S_IDLE;
                end
                default: begin
                    mac_en_r         <= {(ROW*COL){1'b0}};
                    psum_en_r        <= 1'b0;
                    pe_psum_finish_r <= 1'b0;
                    conv_finish_r    <= 1'b0;
                    turn_off_r       <= 1'b0;
                    busy_r           <= 1'b0;
                    state_r          <= S_IDLE;
                end
            endcase
        end
    end

    // MAC_LAT-deep delay line from psum_en/psum_addr to the psum write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                wr_pipe_r[i]    <= 1'b0;
                waddr_pipe_r[i] <= {PSUM_ADDR_BITWIDTH{1'b0}};
            end
        end else if (abort) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                wr_pipe_r[i]    <= 1'b0;
                waddr_pipe_r[i] <= {PSUM_ADDR_BITWIDTH{1'b0}};
            end
        end else begin
            wr_pipe_r[0]    <= psum_en_r;
            waddr_pipe_r[0] <= p_r;
            for (int i = 1; i < MAC_LAT; i++) begin
                wr_pipe_r[i]    <= wr_pipe_r[i-1];
                waddr_pipe_r[i] <= waddr_pipe_r[i-1];
            end
        end
    end

    assign MAC_en             = mac_en_r;
    assign actv_sel           = sel_r;
    assign wgt_sel            = sel_r;
    assign actv_r_addr        = k_r;
    assign wgt_r_addr         = k_r;
    assign psum_en            = psum_en_r;
    assign psum_addr          = p_r;
    assign psum_wr_en         = wr_pipe_r[MAC_LAT-1];
    assign psum_write_addr    = waddr_pipe_r[MAC_LAT-1];
    assign actv_rf1_need_data = actv_need_r[0];
    assign actv_rf2_need_data = actv_need_r[1];
    assign wgt_rf1_need_data  = wgt_need_r[0];
    assign wgt_rf2_need_data  = wgt_need_r[1];
    assign pe_psum_finish     = pe_psum_finish_r;
    assign conv_finish        = conv_finish_r;
    assign turn_off           = turn_off_r;
    assign busy               = busy_r;

endmodule
